// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, bus defaults and opcode constants
package mem_responder_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word store with one synchronous write port and a registered read
module mem_array #(
  parameter int AW = 5,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a,
  input  logic          we,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  // storage is never cleared so preloaded programs survive a CPU reset
  always_ff @(posedge clk)
    if (we) mem[a] <= wdata;
  // read register holds its value between reads
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[a];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated rd/wr responder with loader port; MEM_PARITY_EN adds even parity and parity_err
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          busy,
  output logic          overrun,
  input  logic          ld_en,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
`ifdef MEM_PARITY_EN
  ,
  output logic          parity_err
`endif
);
`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam logic [3:0] WS_LOAD = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  state_t state, next;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] lat_addr, mem_a;
  logic [DW-1:0] lat_din, wdata_raw;
  logic [MW-1:0] wdata, rdata;
  op_t lat_op, op;
  logic go, we, re, stray;
  // in IDLE the live strobe feeds the array directly so a zero-wait access completes next cycle
  assign op = state == IDLE ? (wr ? OP_WR : OP_RD) : lat_op;
  assign go = next == ACCESS;
  assign mem_a = ld_en ? ld_addr : (state == IDLE ? addr : lat_addr);
  assign wdata_raw = ld_en ? ld_data : (state == IDLE ? din : lat_din);
  assign we = ld_en ? ld_we : go && op == OP_WR;
  assign re = go && op == OP_RD;
  assign stray = !ld_en && (state == IDLE ? rd & wr : rd | wr);
  assign ready = state == ACCESS;
  assign busy = state != IDLE;
  assign dout = rdata[DW-1:0];
`ifdef MEM_PARITY_EN
  assign wdata = {^wdata_raw, wdata_raw};
`else
  assign wdata = wdata_raw;
`endif
  // next state and wait counter; the loader preempts everything
  always_comb begin
    next = state;
    cnt_n = cnt;
    if (ld_en) next = IDLE;
    else if (state == IDLE && (rd ^ wr)) begin
      next = WAIT_STATES == 0 ? ACCESS : WAIT;
      cnt_n = WS_LOAD;
    end else if (state == WAIT) begin
      next = cnt == 4'd0 ? ACCESS : WAIT;
      cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state == ACCESS) next = IDLE;
  end
  // state, counter and sticky overrun
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_n;
      overrun <= overrun | stray;
    end
  // request capture
  always_ff @(posedge clk)
    if (state == IDLE && !ld_en && (rd ^ wr)) begin
      lat_addr <= addr;
      lat_din <= din;
      lat_op <= wr ? OP_WR : OP_RD;
    end
`ifdef MEM_PARITY_EN
  // sticky parity error on any completed read whose stored word is odd
  always_ff @(posedge clk)
    if (rst) parity_err <= 1'b0;
    else if (state == ACCESS && lat_op == OP_RD && ^rdata) parity_err <= 1'b1;
`endif
  mem_array #(.AW(AW), .W(MW)) u_mem (
    .clk(clk),
    .rst(rst),
    .a(mem_a),
    .we(we),
    .wdata(wdata),
    .re(re),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors over four instances with different wait-state counts
module tb_mem_responder;
  localparam int N = 4;
  localparam int WS [N] = '{0, 2, 3, 4};
  logic clk = 1'b0;
  logic rst [N];
  logic [4:0] addr [N];
  logic rd [N];
  logic wr [N];
  logic [7:0] din [N];
  logic [7:0] dout [N];
  logic ready [N];
  logic busy [N];
  logic overrun [N];
  logic ld_en [N];
  logic ld_we [N];
  logic [4:0] ld_addr [N];
  logic [7:0] ld_data [N];
`ifdef MEM_PARITY_EN
  logic parity_err [N];
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.AW(5), .DW(8), .WAIT_STATES(WS[g])) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .addr(addr[g]),
      .rd(rd[g]),
      .wr(wr[g]),
      .din(din[g]),
      .dout(dout[g]),
      .ready(ready[g]),
      .busy(busy[g]),
      .overrun(overrun[g]),
      .ld_en(ld_en[g]),
      .ld_we(ld_we[g]),
      .ld_addr(ld_addr[g]),
      .ld_data(ld_data[g])
`ifdef MEM_PARITY_EN
      ,
      .parity_err(parity_err[g])
`endif
    );
  end
  typedef struct {
    int i;
    logic r;
    logic w;
    logic [4:0] a;
    logic [7:0] d;
    int n;
    logic [7:0] q;
    logic ov;
  } vec_t;
  vec_t v [10];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic load(input int i, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en[i] = 1'b1;
    ld_we[i] = 1'b1;
    ld_addr[i] = a;
    ld_data[i] = d;
    @(negedge clk);
    ld_en[i] = 1'b0;
    ld_we[i] = 1'b0;
  endtask
  task automatic access(input int i, input logic r, input logic w, input logic [4:0] a,
                        input logic [7:0] d, output int nr, output int lat, output int nb);
    @(negedge clk);
    rd[i] = r;
    wr[i] = w;
    addr[i] = a;
    din[i] = d;
    @(negedge clk);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    nr = 0;
    lat = 0;
    nb = 0;
    for (int k = 1; k <= 10; k++) begin
      if (ready[i]) begin
        nr++;
        if (lat == 0) lat = k;
      end
      if (busy[i]) nb++;
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nr, lat, nb;
    v[0] = '{0, 1'b1, 1'b0, 5'h03, 8'h00, 1, 8'hA5, 1'b0};
    v[1] = '{0, 1'b1, 1'b0, 5'h1F, 8'h00, 1, 8'h3C, 1'b0};
    v[2] = '{0, 1'b1, 1'b1, 5'h02, 8'hEE, 0, 8'h3C, 1'b1};
    v[3] = '{0, 1'b1, 1'b0, 5'h02, 8'h00, 1, 8'h11, 1'b1};
    v[4] = '{0, 1'b0, 1'b1, 5'h10, 8'h77, 1, 8'h11, 1'b1};
    v[5] = '{0, 1'b1, 1'b0, 5'h10, 8'h00, 1, 8'h77, 1'b1};
    v[6] = '{2, 1'b0, 1'b1, 5'h07, 8'h5A, 1, 8'h00, 1'b0};
    v[7] = '{2, 1'b1, 1'b0, 5'h07, 8'h00, 1, 8'h5A, 1'b0};
    v[8] = '{1, 1'b0, 1'b1, 5'h0A, 8'hC3, 1, 8'h00, 1'b0};
    v[9] = '{1, 1'b1, 1'b0, 5'h0A, 8'h00, 1, 8'hC3, 1'b0};
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      addr[i] = '0;
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      din[i] = '0;
      ld_en[i] = 1'b0;
      ld_we[i] = 1'b0;
      ld_addr[i] = '0;
      ld_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset ready i%0d", i), ready[i], 0);
      check($sformatf("reset busy i%0d", i), busy[i], 0);
      check($sformatf("reset dout i%0d", i), dout[i], 0);
      check($sformatf("reset overrun i%0d", i), overrun[i], 0);
    end
    load(0, 5'h03, 8'hA5);
    load(0, 5'h1F, 8'h3C);
    load(0, 5'h02, 8'h11);
    foreach (v[j]) begin
      access(v[j].i, v[j].r, v[j].w, v[j].a, v[j].d, nr, lat, nb);
      check($sformatf("v%0d ready_count", j), nr, v[j].n);
      check($sformatf("v%0d latency", j), lat, v[j].n != 0 ? 1 + WS[v[j].i] : 0);
      check($sformatf("v%0d busy_cycles", j), nb, v[j].n != 0 ? 1 + WS[v[j].i] : 0);
      check($sformatf("v%0d dout", j), dout[v[j].i], v[j].q);
      check($sformatf("v%0d overrun", j), overrun[v[j].i], v[j].ov);
    end
    // strobe during WAIT of a prior write is ignored and flagged
    @(negedge clk);
    wr[1] = 1'b1;
    addr[1] = 5'h0B;
    din[1] = 8'h44;
    @(negedge clk);
    wr[1] = 1'b0;
    rd[1] = 1'b1;
    addr[1] = 5'h0A;
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rd[1] = 1'b0;
      nr += int'(ready[1]);
    end
    check("busy_strobe ready_count", nr, 1);
    check("busy_strobe overrun", overrun[1], 1);
    check("busy_strobe dout", dout[1], 8'hC3);
    access(1, 1'b1, 1'b0, 5'h0B, 8'h00, nr, lat, nb);
    check("busy_strobe readback", dout[1], 8'h44);
    // loader abort during WAIT
    load(3, 5'h04, 8'h22);
    @(negedge clk);
    wr[3] = 1'b1;
    addr[3] = 5'h04;
    din[3] = 8'h99;
    @(negedge clk);
    wr[3] = 1'b0;
    nr = int'(ready[3]);
    @(negedge clk);
    nr += int'(ready[3]);
    ld_en[3] = 1'b1;
    @(negedge clk);
    ld_en[3] = 1'b0;
    check("abort busy", busy[3], 0);
    for (int k = 0; k < 8; k++) begin
      nr += int'(ready[3]);
      @(negedge clk);
    end
    check("abort ready_count", nr, 0);
    access(3, 1'b1, 1'b0, 5'h04, 8'h00, nr, lat, nb);
    check("abort readback", dout[3], 8'h22);
    check("abort readback latency", lat, 5);
    // reset mid-WAIT keeps memory
    @(negedge clk);
    rd[3] = 1'b1;
    addr[3] = 5'h04;
    @(negedge clk);
    rd[3] = 1'b0;
    @(negedge clk);
    rst[3] = 1'b1;
    @(negedge clk);
    rst[3] = 1'b0;
    check("rst_wait busy", busy[3], 0);
    check("rst_wait dout", dout[3], 0);
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      nr += int'(ready[3]);
      @(negedge clk);
    end
    check("rst_wait ready_count", nr, 0);
    access(3, 1'b1, 1'b0, 5'h04, 8'h00, nr, lat, nb);
    check("rst_wait retained", dout[3], 8'h22);
    // held strobe is re-captured after ready
    @(negedge clk);
    rd[0] = 1'b1;
    addr[0] = 5'h1F;
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rd[0] = 1'b0;
      nr += int'(ready[0]);
    end
    check("held_strobe ready_count", nr, 2);
    check("held_strobe dout", dout[0], 8'h3C);
`ifdef MEM_PARITY_EN
    load(0, 5'h01, 8'h0F);
    g_dut[0].u_dut.u_mem.mem[1][8] = ~g_dut[0].u_dut.u_mem.mem[1][8];
    check("parity before", parity_err[0], 0);
    access(0, 1'b1, 1'b0, 5'h01, 8'h00, nr, lat, nb);
    check("parity dout", dout[0], 8'h0F);
    check("parity err", parity_err[0], 1);
`endif
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("final_rst overrun", overrun[0], 0);
    check("final_rst dout", dout[0], 0);
`ifdef MEM_PARITY_EN
    check("final_rst parity_err", parity_err[0], 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
